// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator turning byte-addressed requests into 64-bit memory beats
module lsu_mem_ctrl #(
    parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_rd_en,
    output logic        ram_wr_en,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wmask,
    output logic [63:0] ram_wr_data,
    input  logic [63:0] ram_rd_data
);
    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, ERR} state_t;

    state_t       state;
    logic         wen;
    logic         sgn;
    logic [1:0]   size;
    logic [63:0]  addr;
    logic [63:0]  wdata;
    logic [63:0]  buf_lo;
    logic [63:0]  buf_hi;
    logic [2:0]   off;
    logic [3:0]   nbytes;
    logic         split;
    logic [15:0]  bmask;
    logic [127:0] wshift;
    logic [7:0]   beat_bmask;
    logic         in_beat;
    logic [3:0]   req_nbytes;
    logic         req_fault;

    // Byte lanes of the latched access spread over two consecutive words
    assign off        = addr[2:0];
    assign nbytes     = 4'd1 << size;
    assign split      = ({1'b0, off} + nbytes) > 4'd8;
    assign bmask      = {8'h00, 8'hFF >> (4'd8 - nbytes)} << off;
    assign wshift     = {64'd0, wdata} << {off, 3'b000};
    assign req_nbytes = 4'd1 << req_size;
    assign req_fault  = (req_addr < MEM_BASE) ||
                        (({1'b0, req_addr} + 65'(req_nbytes)) > ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));

    function automatic logic [63:0] load_val(input logic [127:0] raw, input logic [2:0] o,
                                             input logic [1:0] s, input logic sg);
        logic [127:0] sh;
        logic [63:0]  v;
        sh = raw >> {o, 3'b000};
        v  = sh[63:0];
        return s == 2'd0 ? {{56{sg & v[7]}}, v[7:0]} :
               s == 2'd1 ? {{48{sg & v[15]}}, v[15:0]} :
               s == 2'd2 ? {{32{sg & v[31]}}, v[31:0]} : v;
    endfunction

    // Memory port is driven only while a beat is in flight, low word in BEAT0, high word in BEAT1
    always_comb begin
        in_beat     = (state == BEAT0) || (state == BEAT1);
        ram_rd_en   = in_beat & ~wen;
        ram_wr_en   = in_beat & wen;
        ram_addr    = in_beat ? {addr[63:3], 3'b000} + ((state == BEAT1) ? 64'd8 : 64'd0) : 64'd0;
        beat_bmask  = ram_wr_en ? ((state == BEAT1) ? bmask[15:8] : bmask[7:0]) : 8'd0;
        ram_wr_data = ram_wr_en ? ((state == BEAT1) ? wshift[127:64] : wshift[63:0]) : 64'd0;
    end

    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign ram_wmask[8*i +: 8] = {8{beat_bmask[i]}};
    end

    // Request/response sequencing with one outstanding access and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            wen        <= 1'b0;
            sgn        <= 1'b0;
            size       <= 2'd0;
            addr       <= 64'd0;
            wdata      <= 64'd0;
            buf_lo     <= 64'd0;
            buf_hi     <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wen        <= req_wen;
                        sgn        <= req_signed;
                        size       <= req_size;
                        addr       <= req_addr;
                        wdata      <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_valid <= req_fault;
                        resp_err   <= req_fault;
                        state      <= req_fault ? ERR : BEAT0;
                    end
                end
                BEAT0: begin
                    if (!wen) buf_lo <= ram_rd_data;
                    if (split) begin
                        state <= BEAT1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= wen ? 64'd0 : load_val({64'd0, ram_rd_data}, off, size, sgn);
                    end
                end
                BEAT1: begin
                    if (!wen) buf_hi <= ram_rd_data;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= wen ? 64'd0 : load_val({ram_rd_data, buf_lo}, off, size, sgn);
                end
                RESP, ERR: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 64'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized and directed checks of lsu_mem_ctrl against a byte-level memory model
module tb_lsu_mem_ctrl;
    localparam logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        ram_rd_en;
    logic        ram_wr_en;
    logic [63:0] ram_addr;
    logic [63:0] ram_wmask;
    logic [63:0] ram_wr_data;
    logic [63:0] ram_rd_data;

    logic [63:0] mem [64];
    logic [7:0]  ref_mem [512];
    logic        init_we = 1'b0;
    logic [5:0]  init_idx = 6'd0;
    logic [63:0] init_data = 64'd0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nbeats;
    logic [63:0] b_addr [2];
    logic [63:0] b_mask [2];
    logic [63:0] b_data [2];
    logic [63:0] last_rdata;
    logic        last_err;

    lsu_mem_ctrl #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Memory responder: 64 words aliased over the address space, combinational read, masked write
    assign ram_rd_data = mem[ram_addr[8:3]];
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_data;
        else if (ram_wr_en) mem[ram_addr[8:3]] <= (mem[ram_addr[8:3]] & ~ram_wmask) | (ram_wr_data & ram_wmask);
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_fault(input logic [63:0] a, input logic [1:0] s);
        logic [64:0] last;
        last = {1'b0, a} + (65'd1 << s);
        return (a < MEM_BASE) || (last > ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] s, input logic sg);
        int          n;
        logic [63:0] v;
        n = 1 << s;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[9'(a + 64'(i))];
        if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d, input logic first_word_only);
        int n;
        n = 1 << s;
        for (int i = 0; i < n; i++)
            if (!first_word_only || int'(a[2:0]) + i < 8) ref_mem[9'(a + 64'(i))] = d[8*i +: 8];
    endtask

    function automatic logic mem_ok();
        for (int w = 0; w < 64; w++)
            for (int b = 0; b < 8; b++)
                if (mem[w][8*b +: 8] !== ref_mem[8*w+b]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_idle", 64'(req_ready), 64'd1);
    endtask

    task automatic run(input logic w, input logic [63:0] a, input logic [1:0] s, input logic sg,
                       input logic [63:0] d, input int hold);
        logic        flt;
        logic        spl;
        int          n;
        int          lat;
        logic [63:0] exp_rd;
        n      = 1 << s;
        flt    = ref_fault(a, s);
        spl    = (int'(a[2:0]) + n) > 8;
        exp_rd = (w || flt) ? 64'd0 : ref_load(a, s, sg);
        wait_ready();
        req_valid = 1'b1; req_wen = w; req_addr = a; req_size = s; req_signed = sg; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_wen = 1'($urandom); req_addr = {$urandom, $urandom};
        req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = {$urandom, $urandom};
        lat = 1;
        nbeats = 0;
        while (!resp_valid && lat < 8) begin
            check("busy_ready", 64'(req_ready), 64'd0);
            if (ram_rd_en || ram_wr_en) begin
                if (nbeats < 2) begin
                    b_addr[nbeats] = ram_addr;
                    b_mask[nbeats] = ram_wmask;
                    b_data[nbeats] = ram_wr_data;
                end
                nbeats++;
            end
            @(posedge clk); #1;
            lat++;
        end
        last_rdata = resp_rdata;
        last_err   = resp_err;
        check("latency", 64'(lat), flt ? 64'd1 : spl ? 64'd3 : 64'd2);
        check("beats", 64'(nbeats), flt ? 64'd0 : spl ? 64'd2 : 64'd1);
        check("resp_err", 64'(resp_err), 64'(flt));
        check("resp_rdata", resp_rdata, exp_rd);
        if (!flt) check("beat0_addr", b_addr[0], {a[63:3], 3'b000});
        if (!flt && spl) check("beat1_addr", b_addr[1], {a[63:3], 3'b000} + 64'd8);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_ctl", 64'({resp_valid, req_ready, ram_rd_en, ram_wr_en, resp_err}), 64'({4'b1000, flt}));
            check("hold_data", resp_rdata, exp_rd);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("drain_valid", 64'(resp_valid), 64'd0);
        if (w && !flt) ref_store(a, s, d, 1'b0);
        check("mem_contents", 64'(mem_ok()), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        #3;
        check("rst_ctl", 64'({req_ready, resp_valid, resp_err, ram_rd_en, ram_wr_en}), 64'd0);
        check("rst_data", resp_rdata | ram_addr | ram_wmask | ram_wr_data, 64'd0);
        init_we = 1'b1;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            d = (w == 0) ? 64'h8877_6655_4433_2211 : (w == 1) ? 64'h0000_0000_0000_AA99 : {$urandom, $urandom};
            init_idx  = 6'(w);
            init_data = d;
            for (int b = 0; b < 8; b++) ref_mem[8*w+b] = d[8*b +: 8];
        end
        @(negedge clk);
        init_we = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);

        run(1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'd0, 0);
        check("dir_aligned_load", last_rdata, 64'hFFFF_FFFF_8877_6655);
        check("dir_aligned_load_addr", b_addr[0], 64'h8000_0000);

        run(1'b1, 64'h8000_0013, 2'd1, 1'b0, 64'hABCD, 1);
        check("dir_store_mask", b_mask[0], 64'h0000_00FF_FF00_0000);
        check("dir_store_data", b_data[0], 64'h0000_00AB_CD00_0000);
        run(1'b0, 64'h8000_0013, 2'd1, 1'b0, 64'd0, 0);
        check("dir_store_readback", last_rdata, 64'h0000_0000_0000_ABCD);

        run(1'b0, 64'h8000_0006, 2'd3, 1'b0, 64'd0, 0);
        check("dir_split_load", last_rdata, 64'h0000_0000_AA99_8877);

        run(1'b1, 64'h8000_000E, 2'd2, 1'b0, 64'hDDCC_BBAA, 0);
        check("dir_split_mask0", b_mask[0], 64'hFFFF_0000_0000_0000);
        check("dir_split_data0", b_data[0], 64'hBBAA_0000_0000_0000);
        check("dir_split_addr1", b_addr[1], 64'h8000_0010);
        check("dir_split_mask1", b_mask[1], 64'h0000_0000_0000_FFFF);
        check("dir_split_data1", b_data[1], 64'h0000_0000_0000_DDCC);

        run(1'b0, 64'h7FFF_FFF8, 2'd3, 1'b0, 64'd0, 5);
        check("dir_fault_low", 64'({last_err, last_rdata != 0}), 64'b10);
        run(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 1'b0, 64'd0, 0);
        check("dir_fault_wrap", 64'(last_err), 64'd1);
        run(1'b0, MEM_BASE + MEM_SIZE - 64'd8, 2'd3, 1'b0, 64'd0, 0);
        check("dir_top_ok", 64'(last_err), 64'd0);
        run(1'b0, MEM_BASE + MEM_SIZE - 64'd7, 2'd3, 1'b0, 64'd0, 0);
        check("dir_top_fault", 64'(last_err), 64'd1);

        wait_ready();
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_001E; req_size = 2'd2;
        req_signed = 1'b0; req_wdata = 64'h4433_2211;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_beat0", 64'(ram_wr_en), 64'd1);
        @(posedge clk); #1;
        check("rst_mid_beat1_addr", ram_addr, 64'h8000_0020);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", 64'({req_ready, resp_valid, resp_err, ram_rd_en, ram_wr_en}), 64'd0);
        check("rst_mid_data", resp_rdata | ram_addr | ram_wmask | ram_wr_data, 64'd0);
        ref_store(64'h8000_001E, 2'd2, 64'h4433_2211, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_mem", 64'(mem_ok()), 64'd1);
        check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        run(1'b0, 64'h8000_001E, 2'd2, 1'b0, 64'd0, 0);

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 9))
                0: a = MEM_BASE - 64'($urandom_range(1, 16));
                1: a = MEM_BASE + MEM_SIZE - 64'($urandom_range(1, 16));
                2: a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: a = MEM_BASE + 64'($urandom_range(0, 511));
            endcase
            run(1'($urandom), a, 2'($urandom), 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
